// File: rtl/regfile_writeback_arbiter.sv
// Register-file write arbiter: ALU results win the single write port and LSU results wait in a FIFO; outputs are registered (1-cycle latency).
// LSU is backpressured with lsu_ready = buffer not full; buffered LSU writes to a register the ALU overwrites are squashed.
module regfile_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_W-1:0]          lsu_rd,
  input  logic [DATA_W-1:0]          lsu_data,
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          rd,
  output logic [DATA_W-1:0]          write_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  entry_t             head;
  logic               alu_req;
  logic               push;
  logic               pop;
  logic               push_squashed;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign lsu_ready     = reset_n && (fifo_count < CNT_W'(DEPTH));
  assign alu_req       = alu_valid && (alu_rd != '0);
  assign push          = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign pop           = !alu_req && (fifo_count != '0);
  assign head          = mem[rd_ptr];
  assign push_squashed = alu_req && (lsu_rd == alu_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_req && (mem[i].rd == alu_rd)) begin
          mem[i].live <= 1'b0;
        end
      end
      // The push slot is free (not full), so this never collides with a squash of a live entry.
      if (push) begin
        mem[wr_ptr] <= '{live: !push_squashed, rd: lsu_rd, data: lsu_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (alu_req) begin
      reg_write  <= 1'b1;
      rd         <= alu_rd;
      write_data <= alu_data;
    end else if (pop && head.live) begin
      reg_write  <= 1'b1;
      rd         <= head.rd;
      write_data <= head.data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: one task per scenario with hand-computed expectations.
module tb_regfile_writeback_arbiter;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  regfile_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #1;
    checks++;
    if ({reg_write, rd, write_data} !== 38'd0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", {reg_write, rd, write_data});
    end
    checks++;
    if ({fifo_count, lsu_ready} !== 4'd0) begin
      failures++; $display("FAIL reset_cnt_rdy got=%0h exp=0", {fifo_count, lsu_ready});
    end
    cyc(); cyc();
    reset_n = 1;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%0b exp=1", lsu_ready);
    end
  endtask

  task automatic test_alu_pass();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    checks++;
    if ({reg_write, rd, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++; $display("FAIL alu_pass got=%0h exp=%0h", {reg_write, rd, write_data}, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    alu_rd = 0; alu_data = 32'h1234;
    cyc();
    checks++;
    if ({reg_write, rd, write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      failures++; $display("FAIL alu_x0 got=%0h exp=%0h", {reg_write, rd, write_data}, {1'b0, 5'd5, 32'hDEADBEEF});
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_rd = 5'(k + 1); alu_data = 32'h100 + 32'(k);
      lsu_valid = (k < 2); lsu_rd = 5'(10 + k); lsu_data = 32'h10 + 32'(k);
      cyc();
      checks++;
      if ({reg_write, rd, write_data} !== {1'b1, 5'(k + 1), 32'h100 + 32'(k)}) begin
        failures++; $display("FAIL prio_alu%0d got=%0h exp=%0h", k, {reg_write, rd, write_data}, {1'b1, 5'(k + 1), 32'h100 + 32'(k)});
      end
      checks++;
      if (fifo_count !== ((k == 0) ? 3'd1 : 3'd2)) begin
        failures++; $display("FAIL prio_cnt%0d got=%0d exp=%0d", k, fifo_count, (k == 0) ? 1 : 2);
      end
    end
    idle_inputs();
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd10, 32'h10, 3'd1}) begin
      failures++; $display("FAIL prio_lsu10 got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd10, 32'h10, 3'd1});
    end
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd11, 32'h11, 3'd0}) begin
      failures++; $display("FAIL prio_lsu11 got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd11, 32'h11, 3'd0});
    end
    cyc();
    checks++;
    if (reg_write !== 1'b0) begin
      failures++; $display("FAIL prio_idle got=%0b exp=0", reg_write);
    end
  endtask

  task automatic test_full();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(12 + i); lsu_data = 32'hC0 + 32'(i);
      #1;
      checks++;
      if (lsu_ready !== 1'b1) begin
        failures++; $display("FAIL full_ready%0d got=%0b exp=1", i, lsu_ready);
      end
      cyc();
    end
    checks++;
    if ({fifo_count, lsu_ready} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL full_state got=%0h exp=%0h", {fifo_count, lsu_ready}, {3'd4, 1'b0});
    end
    lsu_rd = 16; lsu_data = 32'hC4;
    cyc();
    checks++;
    if ({fifo_count, lsu_ready, reg_write, rd} !== {3'd4, 1'b0, 1'b1, 5'd7}) begin
      failures++; $display("FAIL full_hold got=%0h exp=%0h", {fifo_count, lsu_ready, reg_write, rd}, {3'd4, 1'b0, 1'b1, 5'd7});
    end
    alu_valid = 0;
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count, lsu_ready} !== {1'b1, 5'd12, 32'hC0, 3'd3, 1'b1}) begin
      failures++; $display("FAIL full_pop1 got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count, lsu_ready}, {1'b1, 5'd12, 32'hC0, 3'd3, 1'b1});
    end
    cyc();
    lsu_valid = 0;
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd13, 32'hC1, 3'd3}) begin
      failures++; $display("FAIL full_pushpop got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd13, 32'hC1, 3'd3});
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'(14 + i), 32'hC2 + 32'(i), 3'(2 - i)}) begin
        failures++; $display("FAIL full_drain%0d got=%0h exp=%0h", i, {reg_write, rd, write_data, fifo_count}, {1'b1, 5'(14 + i), 32'hC2 + 32'(i), 3'(2 - i)});
      end
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 8; lsu_data = 32'hAAAA;
    cyc();
    checks++;
    if ({reg_write, rd, fifo_count} !== {1'b1, 5'd3, 3'd1}) begin
      failures++; $display("FAIL sq_buffer got=%0h exp=%0h", {reg_write, rd, fifo_count}, {1'b1, 5'd3, 3'd1});
    end
    lsu_valid = 0; alu_rd = 8; alu_data = 32'h5555;
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd8, 32'h5555, 3'd1}) begin
      failures++; $display("FAIL sq_alu got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd8, 32'h5555, 3'd1});
    end
    alu_valid = 0;
    cyc();
    checks++;
    if ({reg_write, fifo_count} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL sq_dead_pop got=%0h exp=%0h", {reg_write, fifo_count}, {1'b0, 3'd0});
    end
    // Same-cycle squash: the entry enqueued alongside an ALU write to the same register is dead.
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9999;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'hBBBB;
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd9, 32'h9999, 3'd1}) begin
      failures++; $display("FAIL sq_same got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd9, 32'h9999, 3'd1});
    end
    idle_inputs();
    cyc();
    checks++;
    if ({reg_write, fifo_count} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL sq_same_pop got=%0h exp=%0h", {reg_write, fifo_count}, {1'b0, 3'd0});
    end
  endtask

  task automatic test_x0();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++; $display("FAIL x0_ready got=%0b exp=1", lsu_ready);
    end
    cyc();
    checks++;
    if ({reg_write, fifo_count} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL x0_lsu got=%0h exp=%0h", {reg_write, fifo_count}, {1'b0, 3'd0});
    end
    lsu_valid = 0;
    cyc();
    checks++;
    if (reg_write !== 1'b0) begin
      failures++; $display("FAIL x0_after got=%0b exp=0", reg_write);
    end
    // An ALU result to x0 yields the slot to the buffer.
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20;
    cyc();
    lsu_valid = 0; alu_rd = 0; alu_data = 32'h1;
    cyc();
    checks++;
    if ({reg_write, rd, write_data, fifo_count} !== {1'b1, 5'd20, 32'h20, 3'd0}) begin
      failures++; $display("FAIL x0_alu_yield got=%0h exp=%0h", {reg_write, rd, write_data, fifo_count}, {1'b1, 5'd20, 32'h20, 3'd0});
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = 5'(21 + i); lsu_data = 32'hE0 + 32'(i);
      cyc();
    end
    lsu_valid = 0;
    checks++;
    if (fifo_count !== 3'd3) begin
      failures++; $display("FAIL rm_pre got=%0d exp=3", fifo_count);
    end
    reset_n = 0;
    #1;
    checks++;
    if ({reg_write, fifo_count, lsu_ready, rd, write_data} !== 42'd0) begin
      failures++; $display("FAIL rm_async got=%0h exp=0", {reg_write, fifo_count, lsu_ready, rd, write_data});
    end
    idle_inputs();
    cyc();
    reset_n = 1;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++; $display("FAIL rm_ready got=%0b exp=1", lsu_ready);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({reg_write, fifo_count} !== {1'b0, 3'd0}) begin
        failures++; $display("FAIL rm_stale%0d got=%0h exp=0", i, {reg_write, fifo_count});
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_priority();
    test_full();
    test_squash();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
